// File: rtl/sh4_fpu_fmul.sv
// sh4_fpu_fmul -- three-stage IEEE-754 single-precision multiplier for the
// SH4 FPU datapath. Operands arrive already expanded (sign, unbiased exponent,
// stored fraction and class flags). Denormal operands are flushed to zero and
// the result never contains a denormal.
//
// Ports
//   clk, rst                  clock and synchronous active-high reset
//   in_valid / in_ready       operand handshake (in_ready = pipeline advance)
//   a_*/b_* sign,exp,frac     expanded operands (exp is two's complement, -127..128)
//   a_*/b_* is_zero/inf/nan   operand class flags
//   rm                        0 = round to nearest even, 1 = round toward zero
//   out_valid / out_ready     result handshake
//   out_result                packed single-precision product
//   out_invalid               invalid-operation flag for out_result
module sh4_fpu_fmul #(
   parameter logic [31:0] RST_QNAN = 32'h7FBFFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        a_sign,
   input  logic [8:0]  a_exp,
   input  logic [22:0] a_frac,
   input  logic        a_is_zero,
   input  logic        a_is_inf,
   input  logic        a_is_nan,
   input  logic        b_sign,
   input  logic [8:0]  b_exp,
   input  logic [22:0] b_frac,
   input  logic        b_is_zero,
   input  logic        b_is_inf,
   input  logic        b_is_nan,
   input  logic        rm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_invalid
);

   // Exponent value that marks a zero or denormal operand (biased field 0).
   localparam logic [8:0] EXP_DENORM = 9'h181;

   logic        advance;

   logic        a_zero_eff, b_zero_eff, prod_sign;
   logic        s1_special_c, s1_spec_invalid_c;
   logic [31:0] s1_spec_result_c;
   logic [47:0] s1_prod_c;
   logic signed [9:0] s1_exp_c;

   logic        s1_valid, s1_sign, s1_rm, s1_special, s1_spec_invalid;
   logic [31:0] s1_spec_result;
   logic [47:0] s1_prod;
   logic signed [9:0] s1_exp;

   logic [22:0] s2_frac_c;
   logic        s2_guard_c, s2_sticky_c;
   logic signed [9:0] s2_exp_c;

   logic        s2_valid, s2_sign, s2_rm, s2_special, s2_spec_invalid;
   logic        s2_guard, s2_sticky;
   logic [31:0] s2_spec_result;
   logic [22:0] s2_frac;
   logic signed [9:0] s2_exp;

   logic        round_up, frac_carry;
   logic [22:0] frac_rnd, frac_fin;
   logic signed [9:0] exp_fin;
   logic [31:0] s3_result_c;

   // The whole pipe moves as one: every stage shifts whenever the output slot
   // is empty or is being drained, otherwise everything holds.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // Stage 1 combinational work: flush denormals to zero, decide whether the
   // result is a special case (NaN, invalid, infinity, zero) and form the raw
   // significand product and exponent sum. Special cases are resolved here so
   // later stages only have to carry them along.
   always_comb begin
      a_zero_eff        = a_is_zero || (!a_is_inf && !a_is_nan && (a_exp == EXP_DENORM));
      b_zero_eff        = b_is_zero || (!b_is_inf && !b_is_nan && (b_exp == EXP_DENORM));
      prod_sign         = a_sign ^ b_sign;
      s1_special_c      = 1'b1;
      s1_spec_invalid_c = 1'b0;
      s1_spec_result_c  = '0;
      if (a_is_nan || b_is_nan) begin
         s1_spec_result_c  = RST_QNAN;
         s1_spec_invalid_c = (a_is_nan && a_frac[22]) || (b_is_nan && b_frac[22]);
      end else if ((a_is_inf && b_zero_eff) || (b_is_inf && a_zero_eff)) begin
         s1_spec_result_c  = RST_QNAN;
         s1_spec_invalid_c = 1'b1;
      end else if (a_is_inf || b_is_inf) begin
         s1_spec_result_c = {prod_sign, 8'hFF, 23'h0};
      end else if (a_zero_eff || b_zero_eff) begin
         s1_spec_result_c = {prod_sign, 31'h0};
      end else begin
         s1_special_c = 1'b0;
      end
      s1_prod_c = {24'd0, 1'b1, a_frac} * {24'd0, 1'b1, b_frac};
      s1_exp_c  = $signed({a_exp[8], a_exp}) + $signed({b_exp[8], b_exp});
   end

   // Stage 1 register: multiply / exponent-add results and special-case info.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid        <= 1'b0;
         s1_sign         <= 1'b0;
         s1_rm           <= 1'b0;
         s1_special      <= 1'b0;
         s1_spec_invalid <= 1'b0;
         s1_spec_result  <= '0;
         s1_prod         <= '0;
         s1_exp          <= '0;
      end else if (advance) begin
         s1_valid        <= in_valid;
         s1_sign         <= prod_sign;
         s1_rm           <= rm;
         s1_special      <= s1_special_c;
         s1_spec_invalid <= s1_spec_invalid_c;
         s1_spec_result  <= s1_spec_result_c;
         s1_prod         <= s1_prod_c;
         s1_exp          <= s1_exp_c;
      end
   end

   // Stage 2 combinational work: the product of two [1,2) significands lies in
   // [1,4), so normalisation is at most a one-bit right shift. The hidden bit
   // is known to be 1 afterwards, so only the 23 fraction bits move on.
   always_comb begin
      if (s1_prod[47]) begin
         s2_frac_c   = s1_prod[46:24];
         s2_guard_c  = s1_prod[23];
         s2_sticky_c = |s1_prod[22:0];
         s2_exp_c    = s1_exp + 10'sd1;
      end else begin
         s2_frac_c   = s1_prod[45:23];
         s2_guard_c  = s1_prod[22];
         s2_sticky_c = |s1_prod[21:0];
         s2_exp_c    = s1_exp;
      end
   end

   // Stage 2 register: normalised fraction with guard/sticky for rounding.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid        <= 1'b0;
         s2_sign         <= 1'b0;
         s2_rm           <= 1'b0;
         s2_special      <= 1'b0;
         s2_spec_invalid <= 1'b0;
         s2_spec_result  <= '0;
         s2_frac         <= '0;
         s2_guard        <= 1'b0;
         s2_sticky       <= 1'b0;
         s2_exp          <= '0;
      end else if (advance) begin
         s2_valid        <= s1_valid;
         s2_sign         <= s1_sign;
         s2_rm           <= s1_rm;
         s2_special      <= s1_special;
         s2_spec_invalid <= s1_spec_invalid;
         s2_spec_result  <= s1_spec_result;
         s2_frac         <= s2_frac_c;
         s2_guard        <= s2_guard_c;
         s2_sticky       <= s2_sticky_c;
         s2_exp          <= s2_exp_c;
      end
   end

   // Stage 3 combinational work: round, handle the carry out of the fraction
   // (the significand becomes exactly 1.0 and the exponent steps up), then
   // clamp overflow/underflow and pack. A special case from stage 1 wins.
   always_comb begin
      round_up                = !s2_rm && s2_guard && (s2_sticky || s2_frac[0]);
      {frac_carry, frac_rnd}  = {1'b0, s2_frac} + {23'd0, round_up};
      if (frac_carry) begin
         frac_fin = 23'd0;
         exp_fin  = s2_exp + 10'sd1;
      end else begin
         frac_fin = frac_rnd;
         exp_fin  = s2_exp;
      end
      if (s2_special) begin
         s3_result_c = s2_spec_result;
      end else if (exp_fin > 10'sd127) begin
         s3_result_c = s2_rm ? {s2_sign, 8'hFE, 23'h7FFFFF} : {s2_sign, 8'hFF, 23'h0};
      end else if (exp_fin < -10'sd126) begin
         s3_result_c = {s2_sign, 31'h0};
      end else begin
         s3_result_c = {s2_sign, 8'(exp_fin + 10'sd127), frac_fin};
      end
   end

   // Stage 3 register doubles as the output slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_result  <= '0;
         out_invalid <= 1'b0;
      end else if (advance) begin
         out_valid   <= s2_valid;
         out_result  <= s3_result_c;
         out_invalid <= s2_special && s2_spec_invalid;
      end
   end

endmodule
